// File: rtl/ghash_mult.sv
// ---------------------------------------------------------------------------
// ghash_mult
// Iterative GF(2^128) multiply-accumulate engine for the GHASH update
//     Y <- (Y xor X) * H
// The multiplier is consumed DIGIT_BITS bits per cycle, so one block takes
// N = 128/DIGIT_BITS multiply cycles plus one accept and one DONE cycle.
// All 128-bit values use GCM bit order: bit 127 is the coefficient of x^0.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   H          hash subkey, sampled only while H_valid is high
//   H_valid    one-cycle strobe marking a new subkey
//   clear      level-sensitive: zero the accumulator / abort a multiply
//   blk_in     data block X
//   blk_valid  blk_in is valid
//   blk_ready  block accepted on a cycle where blk_valid && blk_ready
//   Y_out      accumulator value
//   done       one-cycle pulse, Y_out holds the new result
//   h_loaded   a subkey has been captured since reset
//   busy       engine is multiplying or presenting a result
// ---------------------------------------------------------------------------
module ghash_mult #(
    parameter int DIGIT_BITS = 8   // legal: 1, 2, 4, 8, 16, 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] H,
    input  logic         H_valid,
    input  logic         clear,
    input  logic [127:0] blk_in,
    input  logic         blk_valid,
    output logic         blk_ready,
    output logic [127:0] Y_out,
    output logic         done,
    output logic         h_loaded,
    output logic         busy
);

    localparam int N     = 128 / DIGIT_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // x^128 = x^7 + x^2 + x + 1, expressed in GCM (reflected) bit order.
    localparam logic [127:0] R_POLY = {8'hE1, 120'h0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [127:0]       y_q;
    logic [127:0]       h_reg_q;
    logic [127:0]       h_pend_q;
    logic               h_pend_v_q;
    logic               h_loaded_q;
    logic [127:0]       v_q;
    logic [127:0]       z_q;
    logic [127:0]       x_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;

    logic [127:0]       z_d;
    logic [127:0]       v_d;
    logic [127:0]       x_d;
    logic               accept;
    logic               last_digit;
    logic [127:0]       h_eff;

    assign blk_ready  = (state_q == IDLE) && h_loaded_q && !clear;
    assign accept     = blk_valid && blk_ready;
    // A subkey arriving in the accept cycle is used immediately.
    assign h_eff      = H_valid ? H : h_reg_q;
    assign last_digit = (cnt_q == CNT_W'(N - 1));

    // One digit of the shift-and-add multiply: walk the top DIGIT_BITS bits
    // of X (x^0 first), accumulating V into Z and stepping V by one power
    // of x with reduction after every bit.
    always_comb begin
        z_d = z_q;
        v_d = v_q;
        for (int i = 0; i < DIGIT_BITS; i++) begin
            // NOTE: blocking assignments chain the bit steps inside one
            // cycle; each iteration sees the previous iteration's z_d/v_d.
            if (x_q[127 - i]) begin
                z_d = z_d ^ v_d;
            end
            v_d = {1'b0, v_d[127:1]} ^ (v_d[0] ? R_POLY : 128'h0);
        end
        x_d = x_q << DIGIT_BITS;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            y_q        <= '0;
            h_reg_q    <= '0;
            h_pend_q   <= '0;
            h_pend_v_q <= 1'b0;
            h_loaded_q <= 1'b0;
            v_q        <= '0;
            z_q        <= '0;
            x_q        <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (H_valid) begin
                        h_reg_q    <= H;
                        h_loaded_q <= 1'b1;
                    end
                    if (clear) begin
                        y_q <= '0;
                    end else if (accept) begin
                        x_q     <= y_q ^ blk_in;
                        v_q     <= h_eff;
                        z_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= MUL;
                    end
                end

                MUL: begin
                    if (clear) begin
                        // Abort: drop the partial product and return to IDLE,
                        // committing any subkey that arrived meanwhile.
                        y_q     <= '0;
                        state_q <= IDLE;
                        if (H_valid) begin
                            h_reg_q    <= H;
                            h_pend_v_q <= 1'b0;
                        end else if (h_pend_v_q) begin
                            h_reg_q    <= h_pend_q;
                            h_pend_v_q <= 1'b0;
                        end
                    end else begin
                        // New subkeys are parked; the running V is untouched.
                        if (H_valid) begin
                            h_pend_q   <= H;
                            h_pend_v_q <= 1'b1;
                        end
                        z_q   <= z_d;
                        v_q   <= v_d;
                        x_q   <= x_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_digit) begin
                            y_q     <= z_d;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (clear) begin
                        y_q <= '0;
                    end
                    state_q <= IDLE;
                    // A subkey strobed in this very cycle is newer than any
                    // parked one, so it wins.
                    if (H_valid) begin
                        h_reg_q    <= H;
                        h_pend_v_q <= 1'b0;
                    end else if (h_pend_v_q) begin
                        h_reg_q    <= h_pend_q;
                        h_pend_v_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Y_out    = y_q;
    assign done     = done_q;
    assign h_loaded = h_loaded_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ghash_mult.sv
// ---------------------------------------------------------------------------
// tb_ghash_mult
// Self-checking bench for ghash_mult. Three instances run side by side with
// DIGIT_BITS = 8, 1 and 32. Expected accumulator values come from a
// polynomial-domain model: operands are bit-reversed into ordinary
// polynomial form, multiplied carry-less into 255 bits and reduced modulo
// x^128 + x^7 + x^2 + x + 1.
// ---------------------------------------------------------------------------
module tb_ghash_mult;

    localparam int NDUT = 3;

    logic         clk = 1'b0;
    logic         rst;

    logic [127:0] h_s   [NDUT];
    logic         hv_s  [NDUT];
    logic         clr_s [NDUT];
    logic [127:0] blk_s [NDUT];
    logic         bv_s  [NDUT];
    logic         rdy_s [NDUT];
    logic [127:0] y_s   [NDUT];
    logic         done_s[NDUT];
    logic         hl_s  [NDUT];
    logic         busy_s[NDUT];

    logic [127:0] ref_y [NDUT];
    logic [127:0] ref_h [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ghash_mult #(
            .DIGIT_BITS(g == 0 ? 8 : (g == 1 ? 1 : 32))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .H        (h_s[g]),
            .H_valid  (hv_s[g]),
            .clear    (clr_s[g]),
            .blk_in   (blk_s[g]),
            .blk_valid(bv_s[g]),
            .blk_ready(rdy_s[g]),
            .Y_out    (y_s[g]),
            .done     (done_s[g]),
            .h_loaded (hl_s[g]),
            .busy     (busy_s[g])
        );
    end

    function automatic int nmul(input int d);
        return (d == 0) ? 16 : ((d == 1) ? 128 : 4);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference product in GF(2^128), GCM bit order in and out.
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] h);
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] r;
        logic [255:0] p;
        logic [255:0] poly;
        p    = '0;
        poly = 256'h87;
        poly[128] = 1'b1;
        for (int i = 0; i < 128; i++) begin
            a[i] = x[127 - i];
            b[i] = h[127 - i];
        end
        for (int i = 0; i < 128; i++) begin
            if (a[i]) p = p ^ ({128'h0, b} << i);
        end
        for (int i = 254; i >= 128; i--) begin
            if (p[i]) p = p ^ (poly << (i - 128));
        end
        for (int i = 0; i < 128; i++) begin
            r[127 - i] = p[i];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_h(input int d, input logic [127:0] h);
        h_s[d]  = h;
        hv_s[d] = 1'b1;
        tick();
        hv_s[d] = 1'b0;
        ref_h[d] = h;
    endtask

    task automatic do_clear(input int d);
        clr_s[d] = 1'b1;
        tick();
        clr_s[d] = 1'b0;
        ref_y[d] = '0;
    endtask

    // Feed one block and follow it through MUL and DONE. Optional same-cycle
    // subkey (byp/hb) and up to two subkey strobes in MUL cycles pa and pb.
    task automatic run_block(input int d, input logic [127:0] x, input bit byp,
                             input logic [127:0] hb, input int pa, input logic [127:0] ha,
                             input int pb, input logic [127:0] hc, input string nm);
        int waited;
        int done_at;
        int n;
        bit bad_ready;
        bit y_moved;
        logic [127:0] exp_y;
        n = nmul(d);
        waited = 0;
        while (rdy_s[d] !== 1'b1 && waited < 64) begin
            tick();
            waited++;
        end
        n_checks++;
        if (rdy_s[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready: got %b expected 1", nm, rdy_s[d]);
        end
        blk_s[d] = x;
        bv_s[d]  = 1'b1;
        if (byp) begin
            h_s[d]   = hb;
            hv_s[d]  = 1'b1;
            ref_h[d] = hb;
        end
        exp_y = gf_mul(ref_y[d] ^ x, ref_h[d]);
        tick();
        bv_s[d] = 1'b0;
        hv_s[d] = 1'b0;
        done_at   = -1;
        bad_ready = 1'b0;
        y_moved   = 1'b0;
        for (int i = 1; i <= n + 4 && done_at < 0; i++) begin
            hv_s[d] = (i == pa) || (i == pb);
            h_s[d]  = (i == pb) ? hc : ha;
            if (rdy_s[d] !== 1'b0 || busy_s[d] !== 1'b1) bad_ready = 1'b1;
            if (y_s[d] !== ref_y[d]) y_moved = 1'b1;
            tick();
            if (done_s[d] === 1'b1) done_at = i;
        end
        hv_s[d] = 1'b0;
        n_checks++;
        if (done_at != n) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d expected %0d", nm, done_at, n);
        end
        n_checks++;
        if (bad_ready || y_moved) begin
            n_fail++;
            $display("FAIL %s mul_phase: ready/busy_wrong=%b y_changed=%b expected 0 0", nm, bad_ready, y_moved);
        end
        n_checks++;
        if (y_s[d] !== exp_y) begin
            n_fail++;
            $display("FAIL %s y_out: got %h expected %h", nm, y_s[d], exp_y);
        end
        n_checks++;
        if ({rdy_s[d], busy_s[d]} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s done_cycle ready/busy: got %b%b expected 01", nm, rdy_s[d], busy_s[d]);
        end
        tick();
        n_checks++;
        if ({done_s[d], rdy_s[d], busy_s[d]} !== 3'b010 || y_s[d] !== exp_y) begin
            n_fail++;
            $display("FAIL %s return_idle: done/ready/busy %b%b%b y %h expected 010 y %h",
                     nm, done_s[d], rdy_s[d], busy_s[d], y_s[d], exp_y);
        end
        ref_y[d] = exp_y;
        if (pb > 0)      ref_h[d] = hc;
        else if (pa > 0) ref_h[d] = ha;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if ({y_s[d], done_s[d], hl_s[d], busy_s[d], rdy_s[d]} !== '0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: y %h done %b h_loaded %b busy %b ready %b expected all 0",
                         d, y_s[d], done_s[d], hl_s[d], busy_s[d], rdy_s[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_no_key();
        bv_s[0]  = 1'b1;
        blk_s[0] = rnd128();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({rdy_s[0], busy_s[0]} !== 2'b00) begin
                n_fail++;
                $display("FAIL no_key ready/busy: got %b%b expected 00", rdy_s[0], busy_s[0]);
            end
            tick();
        end
        h_s[0]  = '0;
        hv_s[0] = 1'b1;
        tick();
        hv_s[0] = 1'b0;
        bv_s[0] = 1'b0;
        ref_h[0] = '0;
        n_checks++;
        if ({hl_s[0], rdy_s[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL key_latency h_loaded/ready: got %b%b expected 11", hl_s[0], rdy_s[0]);
        end
        run_block(0, rnd128(), 1'b0, '0, 0, '0, 0, '0, "zero_key");
        n_checks++;
        if (y_s[0] !== 128'h0) begin
            n_fail++;
            $display("FAIL zero_key_y: got %h expected 0", y_s[0]);
        end
    endtask

    task automatic test_identity();
        do_clear(0);
        load_h(0, {1'b1, 127'h0});
        run_block(0, 128'h0123456789abcdeffedcba9876543210, 1'b0, '0, 0, '0, 0, '0, "identity");
        n_checks++;
        if (y_s[0] !== 128'h0123456789abcdeffedcba9876543210) begin
            n_fail++;
            $display("FAIL identity_const: got %h expected 0123456789abcdeffedcba9876543210", y_s[0]);
        end
    endtask

    task automatic test_gcm_vectors(input int d);
        do_clear(d);
        load_h(d, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        run_block(d, 128'h0388dace60b6a392f328c2b971b2fe78, 1'b0, '0, 0, '0, 0, '0, "gcm_c1");
        n_checks++;
        if (y_s[d] !== 128'h5e2ec746917062882c85b0685353deb7) begin
            n_fail++;
            $display("FAIL gcm_c1 dut%0d: got %h expected 5e2ec746917062882c85b0685353deb7", d, y_s[d]);
        end
        run_block(d, 128'h00000000000000000000000000000080, 1'b0, '0, 0, '0, 0, '0, "gcm_len");
        n_checks++;
        if (y_s[d] !== 128'hf38cbb1ad69223dcc3457ae5b6b0f885) begin
            n_fail++;
            $display("FAIL gcm_len dut%0d: got %h expected f38cbb1ad69223dcc3457ae5b6b0f885", d, y_s[d]);
        end
    endtask

    task automatic test_random();
        do_clear(0);
        load_h(0, rnd128());
        for (int i = 0; i < 6; i++) begin
            run_block(0, rnd128(), 1'($urandom_range(0, 1)), rnd128(), 0, '0, 0, '0, "random");
        end
    endtask

    task automatic test_back_to_back();
        // Blocks offered continuously: each waits only for blk_ready.
        for (int i = 0; i < 3; i++) begin
            run_block(0, rnd128(), 1'b0, '0, 0, '0, 0, '0, "back_to_back");
        end
    endtask

    task automatic test_h_during_mul();
        run_block(0, rnd128(), 1'b0, '0, 3, rnd128(), 0, '0, "h_mid_old");
        run_block(0, rnd128(), 1'b0, '0, 0, '0, 0, '0, "h_mid_new");
        run_block(0, rnd128(), 1'b0, '0, 2, rnd128(), 9, rnd128(), "h_two_strobes");
        run_block(0, rnd128(), 1'b0, '0, 0, '0, 0, '0, "h_last_wins");
    endtask

    task automatic test_clear();
        logic [127:0] hn;
        bit saw_done;
        hn = rnd128();
        run_block(0, rnd128(), 1'b0, '0, 0, '0, 0, '0, "pre_clear");
        blk_s[0] = rnd128();
        bv_s[0]  = 1'b1;
        tick();                 // MUL cycle 1
        bv_s[0]  = 1'b0;
        tick();                 // MUL cycle 2
        h_s[0]   = hn;
        hv_s[0]  = 1'b1;
        tick();                 // MUL cycle 3
        hv_s[0]  = 1'b0;
        clr_s[0] = 1'b1;
        tick();
        n_checks++;
        if ({y_s[0], done_s[0], busy_s[0], rdy_s[0]} !== '0) begin
            n_fail++;
            $display("FAIL clear_abort: y %h done %b busy %b ready %b expected all 0",
                     y_s[0], done_s[0], busy_s[0], rdy_s[0]);
        end
        clr_s[0] = 1'b0;
        #1;
        n_checks++;
        if (rdy_s[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_abort_ready: got %b expected 1", rdy_s[0]);
        end
        saw_done = 1'b0;
        for (int i = 0; i < nmul(0) + 2; i++) begin
            tick();
            if (done_s[0] !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL clear_no_done: got done pulse expected none");
        end
        ref_y[0] = '0;
        ref_h[0] = hn;
        run_block(0, rnd128(), 1'b0, '0, 0, '0, 0, '0, "post_abort_key");

        // clear and blk_valid together in IDLE: no accept, Y zeroed.
        clr_s[0] = 1'b1;
        bv_s[0]  = 1'b1;
        blk_s[0] = rnd128();
        #1;
        n_checks++;
        if (rdy_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_blocks_ready: got %b expected 0", rdy_s[0]);
        end
        tick();
        clr_s[0] = 1'b0;
        bv_s[0]  = 1'b0;
        n_checks++;
        if (busy_s[0] !== 1'b0 || y_s[0] !== 128'h0) begin
            n_fail++;
            $display("FAIL clear_idle: busy %b y %h expected 0 0", busy_s[0], y_s[0]);
        end
        ref_y[0] = '0;
    endtask

    task automatic test_reset_mid();
        bit bad;
        blk_s[0] = rnd128();
        bv_s[0]  = 1'b1;
        tick();
        bv_s[0]  = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({y_s[0], done_s[0], hl_s[0], busy_s[0], rdy_s[0]} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: y %h done %b h_loaded %b busy %b ready %b expected all 0",
                     y_s[0], done_s[0], hl_s[0], busy_s[0], rdy_s[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            ref_y[d] = '0;
            ref_h[d] = '0;
        end
        bv_s[0]  = 1'b1;
        blk_s[0] = rnd128();
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({hl_s[0], rdy_s[0], busy_s[0]} !== 3'b000) bad = 1'b1;
        end
        bv_s[0] = 1'b0;
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_needs_key: h_loaded/ready/busy went high, expected 000");
        end
        load_h(0, rnd128());
        run_block(0, rnd128(), 1'b0, '0, 0, '0, 0, '0, "after_reset");
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            h_s[d]   = '0;
            hv_s[d]  = 1'b0;
            clr_s[d] = 1'b0;
            blk_s[d] = '0;
            bv_s[d]  = 1'b0;
            ref_y[d] = '0;
            ref_h[d] = '0;
        end
        test_reset();
        test_no_key();
        test_identity();
        for (int d = 0; d < NDUT; d++) test_gcm_vectors(d);
        test_random();
        test_back_to_back();
        test_h_during_mul();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ghash_mult.md
# ghash_mult

Iterative GF(2^128) multiply-accumulate engine computing the GHASH update Y <- (Y xor X) * H. It sits directly downstream of the GHASH subkey generator and consumes its H / H_valid outputs unmodified. Ciphertext and AAD blocks arrive on a valid/ready stream, and the running tag accumulator Y is exposed to the GCM tag stage. Multiplication is digit-serial, processing DIGIT_BITS bits of the multiplier per cycle.

## Interface
- DIGIT_BITS, default 8: multiplier bits processed per cycle.
  - Legal values: 1, 2, 4, 8, 16, 32.
  - N = 128/DIGIT_BITS.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high. One clock; reset is asynchronous and active-high.
- H  input  128  hash subkey from the subkey generator; sampled only when H_valid=1.
- H_valid  input  1  one-cycle strobe marking a new H.
- clear  input  1  zero the accumulator; level-sampled each cycle.
- blk_in  input  128  data block X in GCM bit order (bit 127 = coefficient of x^0).
- blk_valid  input  1  blk_in is valid.
- blk_ready  output  1  block accepted on a cycle where blk_valid && blk_ready.
- Y_out  output  128  accumulator value.
- done  output  1  one-cycle pulse; Y_out holds the new result.
- h_loaded  output  1  a subkey has been captured since reset.
- busy  output  1  state != IDLE.

## Operation
- States and transitions:
  - IDLE -> MUL on block accept.
  - MUL -> DONE after N MUL cycles.
  - DONE -> IDLE unconditionally.
- blk_ready = (state==IDLE) && h_loaded && !clear.
- On accept:
  - X_reg <- Y xor blk_in.
  - V <- H_eff, where H_eff = H if H_valid is high in the same cycle, else h_reg.
  - Z <- 0; digit counter <- 0.
- Each MUL cycle handles DIGIT_BITS bits of X_reg, MSB (bit 127) first. Per bit:
  - if the bit is 1, Z ^= V;
  - then V = (V>>1) xor (V[0] ? 0xE1<<120 : 0).
- Last MUL cycle: Y <- final Z.
- DONE: done=1 and Y_out shows the new Y.
- H handling:
  - H_valid in IDLE: h_reg <- H, h_loaded <- 1.
  - H_valid in MUL/DONE: H goes to h_pend and h_pend_v <- 1. The in-flight multiply keeps its V, unaffected.
  - On DONE->IDLE with h_pend_v: h_reg <- h_pend, h_pend_v <- 0.
  - A second H_valid before that overwrites h_pend (last wins).
- H_valid does not clear Y. A new key requires an explicit clear.
- clear:
  - In IDLE: Y <- 0 next edge.
  - In MUL or DONE: abort. Y <- 0, state <- IDLE, no done pulse. Any h_pend is applied as on a normal return.
  - clear has priority over block accept, because blk_ready is forced low.
- Reset values: state IDLE, Y/h_reg/h_pend/V/Z/X_reg = 0, h_loaded=0, h_pend_v=0, done=0, busy=0, blk_ready=0.
- Reset asserted mid-multiply discards everything. Work resumes only after a new H_valid.
- Arithmetic: XOR only; no carries. Reduction polynomial x^128+x^7+x^2+x+1.

## Timing
- Accept on edge k:
  - MUL occupies cycles k+1 .. k+N.
  - done=1 and Y_out updated in cycle k+N+1.
  - blk_ready returns in cycle k+N+2.
- Throughput: one block per N+2 cycles (18 cycles at DIGIT_BITS=8).
- Y_out is stable at all times except the DONE transition and clear.
- Latency from H_valid in IDLE to h_loaded=1 / blk_ready=1: one cycle.
- Same-cycle H_valid and accept: the block uses the new H (bypass).
- done is never asserted in two consecutive cycles.

## Test plan
- Reset, H_valid with H=0x8000...0 (field identity), blk_in=0x0123456789abcdeffedcba9876543210 -> done at cycle k+N+1 and Y_out=0x0123456789abcdeffedcba9876543210. blk_ready stays low until cycle k+N+2.
- GCM test case 2: H=66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Feed 0388dace60b6a392f328c2b971b2fe78 -> Y_out=5e2ec746917062882c85b0685353deb7.
  - Then feed length block 00000000000000000000000000000080 -> Y_out=f38cbb1ad69223dcc3457ae5b6b0f885.
  - Repeat for DIGIT_BITS = 1, 8, 32 with identical results.
- Before any H_valid: blk_valid=1 -> blk_ready=0 and no accept. H_valid with H=0, then any block -> Y_out=0.
- H_valid with a new H during MUL -> the current result is computed with the old H. The next block uses the new H. Two H_valid strobes during one multiply -> the last one is used.
- clear asserted in MUL cycle 3 -> no done, Y_out=0 next cycle, back to IDLE. clear together with blk_valid in IDLE -> no accept, Y=0.
- rst mid-MUL -> all outputs 0 immediately (asynchronous). h_loaded=0 until the next H_valid.
